// File: rtl/rect_pos_sched.sv
// rect_pos_sched: frame-synchronous position scheduler for the rectangle overlay.
// Build macro RECT_POS_SCHED_CLAMP_EN clamps captured positions so the rectangle stays on screen.
module rect_pos_sched #(
  parameter int H_RES  = 1024,
  parameter int V_RES  = 768,
  parameter int RECT_W = 48,
  parameter int RECT_H = 64,
  parameter int XINIT  = 0,
  parameter int YINIT  = 0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        req_a,
  input  logic [11:0] xpos_a,
  input  logic [11:0] ypos_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [11:0] xpos_b,
  input  logic [11:0] ypos_b,
  output logic        ack_b,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        pending,
  output logic        frame_tick
);

  localparam logic [11:0] X_MAX = 12'(H_RES - RECT_W);
  localparam logic [11:0] Y_MAX = 12'(V_RES - RECT_H);
`ifdef RECT_POS_SCHED_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t      state;
  logic        vblnk_d;
  logic        last_grant;  // 0: port A won last, 1: port B won last
  logic        vblnk_rise;
  logic        grant_a;
  logic        grant_b;
  logic        capture;
  logic [11:0] cap_x;
  logic [11:0] cap_y;
  logic [11:0] pend_x;
  logic [11:0] pend_y;

  function automatic logic [11:0] sat_pos(input logic [11:0] v, input logic [11:0] lim);
    return (CLAMP_EN && (v > lim)) ? lim : v;
  endfunction

  always_comb begin
    vblnk_rise = vblnk_in & ~vblnk_d;
    // On a tie the port that did not win last time is granted.
    grant_a    = req_a & (~req_b | last_grant);
    grant_b    = req_b & ~grant_a;
    capture    = (state == IDLE) & (grant_a | grant_b);
    cap_x      = sat_pos(grant_a ? xpos_a : xpos_b, X_MAX);
    cap_y      = sat_pos(grant_a ? ypos_a : ypos_b, Y_MAX);
  end

  assign pending = (state == PEND);

  // Capture stage: pending coordinates, only meaningful while in PEND
  always_ff @(posedge pclk) begin
    if (capture) begin
      pend_x <= cap_x;
      pend_y <= cap_y;
    end
  end

  // Commit stage: arbitration state, acks, frame tick and committed position
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      vblnk_d    <= 1'b0;
      last_grant <= 1'b1;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      frame_tick <= 1'b0;
      xpos       <= 12'(XINIT);
      ypos       <= 12'(YINIT);
    end else begin
      vblnk_d    <= vblnk_in;
      frame_tick <= vblnk_rise;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      if (state == IDLE) begin
        if (capture) begin
          ack_a      <= grant_a;
          ack_b      <= grant_b;
          last_grant <= grant_b;
          state      <= PEND;
        end
      end else if (vblnk_rise) begin
        xpos  <= pend_x;
        ypos  <= pend_y;
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_rect_pos_sched.sv
// Scoreboard bench for rect_pos_sched: randomized and directed requests against a frame-level reference model.
module tb_rect_pos_sched;

  localparam int FRAME = 32;
  localparam int VBL   = 8;
  localparam int XINIT = 0;
  localparam int YINIT = 0;
  localparam int XLIM  = 976;
  localparam int YLIM  = 704;
`ifdef RECT_POS_SCHED_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic        pclk;
  logic        rst;
  logic        vblnk_in;
  logic        req_a, req_b;
  logic [11:0] xpos_a, ypos_a, xpos_b, ypos_b;
  logic        ack_a, ack_b;
  logic [11:0] xpos, ypos;
  logic        pending, frame_tick;

  rect_pos_sched #(.XINIT(XINIT), .YINIT(YINIT)) dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in),
    .req_a(req_a), .xpos_a(xpos_a), .ypos_a(ypos_a), .ack_a(ack_a),
    .req_b(req_b), .xpos_b(xpos_b), .ypos_b(ypos_b), .ack_b(ack_b),
    .xpos(xpos), .ypos(ypos), .pending(pending), .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } pos_t;

  int   checks = 0;
  int   errors = 0;
  int   fc = 0;
  int   n_ticks = 0;

  pos_t commit_q[$];
  bit   tick_q[$];
  bit   ack_q[$];

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] lim(input logic [11:0] v, input int mx);
    return (CLAMP && (int'(v) > mx)) ? 12'(mx) : v;
  endfunction

  // Reference model: one pending slot, round-robin grant, commit on each vblank rise
  bit   m_pend, m_last, m_vd, m_rise, m_port;
  always @(posedge pclk) begin
    if (!rst) begin
      m_pend = 1'b0;
      m_last = 1'b1;
      m_vd   = 1'b0;
      commit_q.delete();
    end else begin
      m_rise = vblnk_in && !m_vd;
      m_vd   = vblnk_in;
      if (m_rise) tick_q.push_back(m_pend);
      if (m_pend) begin
        if (m_rise) m_pend = 1'b0;
      end else if (req_a || req_b) begin
        m_port = (req_a && req_b) ? !m_last : req_b;
        m_last = m_port;
        ack_q.push_back(m_port);
        if (m_port) commit_q.push_back('{x: lim(xpos_b, XLIM), y: lim(ypos_b, YLIM)});
        else        commit_q.push_back('{x: lim(xpos_a, XLIM), y: lim(ypos_a, YLIM)});
        m_pend = 1'b1;
      end
    end
  end

  // Monitor: pops expected events whenever the DUT presents them
  logic [11:0] cur_x = 12'(XINIT);
  logic [11:0] cur_y = 12'(YINIT);
  initial begin
    bit   e;
    pos_t p;
    forever begin
      @(posedge pclk);
      #1;
      if (!rst) begin
        chk("reset_pulses", int'({ack_a, ack_b, pending, frame_tick}), 0);
        chk("reset_xpos", int'(xpos), XINIT);
        chk("reset_ypos", int'(ypos), YINIT);
        cur_x = 12'(XINIT);
        cur_y = 12'(YINIT);
        ack_q.delete();
        tick_q.delete();
      end else begin
        chk("pending", int'(pending), int'(m_pend));
        if (ack_q.size() > 0) begin
          e = ack_q.pop_front();
          chk("ack_port", int'({ack_a, ack_b}), e ? 1 : 2);
        end else if (ack_a || ack_b) begin
          chk("ack_unexpected", int'({ack_a, ack_b}), 0);
        end
        if (tick_q.size() > 0) begin
          e = tick_q.pop_front();
          chk("frame_tick", int'(frame_tick), 1);
          if (e && commit_q.size() > 0) begin
            p = commit_q.pop_front();
            cur_x = p.x;
            cur_y = p.y;
          end
        end else if (frame_tick) begin
          chk("tick_unexpected", int'(frame_tick), 0);
        end
        if (frame_tick) n_ticks++;
        chk("xpos", int'(xpos), int'(cur_x));
        chk("ypos", int'(ypos), int'(cur_y));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d checks expected completion", checks);
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(negedge pclk);
    fc = (fc == FRAME - 1) ? 0 : fc + 1;
    vblnk_in = (fc >= FRAME - VBL);
  endtask

  task automatic wait_ack(input bit port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      cyc();
      if (port ? ack_b : ack_a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(port ? "ack_b_timeout" : "ack_a_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (!pending) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) chk("commit_timeout", int'(pending), 0);
  endtask

  task automatic wait_fc(input int target);
    for (int i = 0; i < FRAME + 1; i++) begin
      if (fc == target) break;
      cyc();
    end
  endtask

  function automatic logic [11:0] rand_pos();
    return ($urandom_range(0, 3) == 0) ? 12'($urandom_range(900, 4095)) : 12'($urandom_range(0, 1000));
  endfunction

  initial begin
    bit ok;
    bit saw_a;
    int t0;
    int wa, wb;
    bit order[$];

    rst = 1'b0; vblnk_in = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    xpos_a = '0; ypos_a = '0; xpos_b = '0; ypos_b = '0;

    // Reset, then three idle frames
    repeat (3) cyc();
    rst = 1'b1;
    fc = 0; vblnk_in = 1'b0;
    t0 = n_ticks;
    repeat (3 * FRAME) cyc();
    chk("idle_tick_count", n_ticks - t0, 3);
    chk("idle_xpos", int'(xpos), XINIT);

    // Single request mid-frame
    wait_fc(5);
    req_a = 1'b1; xpos_a = 12'd100; ypos_a = 12'd200;
    wait_ack(1'b0, ok);
    req_a = 1'b0;
    chk("single_pending", int'(pending), 1);
    chk("single_hold_x", int'(xpos), XINIT);
    wait_idle();
    chk("single_x", int'(xpos), 100);
    chk("single_y", int'(ypos), 200);

    // Fairness: both requests held from reset
    rst = 1'b0;
    req_a = 1'b1; xpos_a = 12'd10; ypos_a = 12'd11;
    req_b = 1'b1; xpos_b = 12'd20; ypos_b = 12'd21;
    repeat (2) cyc();
    rst = 1'b1;
    repeat (4 * FRAME) begin
      cyc();
      if (ack_a) begin order.push_back(1'b0); xpos_a = xpos_a + 12'd1; end
      if (ack_b) begin order.push_back(1'b1); xpos_b = xpos_b + 12'd1; end
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("fair_ack_count", int'(order.size() >= 4), 1);
    if (order.size() >= 4)
      for (int i = 0; i < 4; i++) chk("fair_order", int'(order[i]), i % 2);
    wait_idle();

    // Same-edge race: request lands on the vblank rise while idle
    wait_fc(FRAME - VBL - 1);
    cyc();
    req_b = 1'b1; xpos_b = 12'd300; ypos_b = 12'd400;
    cyc();
    chk("race_ack_b", int'(ack_b), 1);
    req_b = 1'b0;
    cyc();
    wait_fc(FRAME - VBL);
    chk("race_deferred", int'(pending), 1);
    cyc();
    chk("race_commit_pending", int'(pending), 0);
    chk("race_x", int'(xpos), 300);
    chk("race_y", int'(ypos), 400);

    // Clamp boundary
    req_a = 1'b1; xpos_a = 12'd1020; ypos_a = 12'd760;
    wait_ack(1'b0, ok);
    req_a = 1'b0;
    wait_idle();
    chk("clamp_x", int'(xpos), CLAMP ? 976 : 1020);
    chk("clamp_y", int'(ypos), CLAMP ? 704 : 760);

    // Mid-operation reset discards the pending update
    wait_fc(2);
    req_a = 1'b1; xpos_a = 12'd500; ypos_a = 12'd600;
    wait_ack(1'b0, ok);
    req_a = 1'b0;
    chk("rst_pre_pending", int'(pending), 1);
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    repeat (FRAME + 2) cyc();
    chk("rst_no_commit_x", int'(xpos), XINIT);
    chk("rst_no_commit_y", int'(ypos), YINIT);
    chk("rst_no_pending", int'(pending), 0);

    // Cancel: port A drops its request while B's update is pending
    wait_fc(2);
    req_b = 1'b1; xpos_b = 12'd777; ypos_b = 12'd111;
    wait_ack(1'b1, ok);
    req_b = 1'b0;
    saw_a = 1'b0;
    req_a = 1'b1; xpos_a = 12'd888; ypos_a = 12'd222;
    repeat (5) begin
      cyc();
      saw_a |= ack_a;
    end
    req_a = 1'b0;
    repeat (2 * FRAME) begin
      cyc();
      saw_a |= ack_a;
    end
    chk("cancel_no_ack", int'(saw_a), 0);
    chk("cancel_x", int'(xpos), 777);
    chk("cancel_y", int'(ypos), 111);

    // Randomized traffic with occasional cancels
    wa = 0; wb = 0;
    repeat (3000) begin
      cyc();
      if (req_a) begin
        if (ack_a) req_a = 1'b0;
        else if (++wa > 4 * FRAME) begin chk("rand_ack_a_timeout", int'(ack_a), 1); req_a = 1'b0; end
        else if ($urandom_range(0, 63) == 0) req_a = 1'b0;
      end else if ($urandom_range(0, 11) == 0) begin
        req_a = 1'b1; xpos_a = rand_pos(); ypos_a = rand_pos(); wa = 0;
      end
      if (req_b) begin
        if (ack_b) req_b = 1'b0;
        else if (++wb > 4 * FRAME) begin chk("rand_ack_b_timeout", int'(ack_b), 1); req_b = 1'b0; end
        else if ($urandom_range(0, 63) == 0) req_b = 1'b0;
      end else if ($urandom_range(0, 11) == 0) begin
        req_b = 1'b1; xpos_b = rand_pos(); ypos_b = rand_pos(); wb = 0;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    cyc();
    wait_idle();
    repeat (2) cyc();
    chk("drain_commit_q", commit_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
